// File: rtl/frame_anim_ctl.sv
// Frame-driven animation controller: steps a displayed register value and a
// ping-pong zoom level at programmable frame rates, with run/pause, direction and load.
module frame_anim_ctl #(
   parameter int                DATA_W   = 16,
   parameter logic [DATA_W-1:0] INIT     = DATA_W'(16'h0019),
   parameter int                STEP     = 1,
   parameter int                REG_DIV  = 16,
   parameter int                ZOOM_W   = 3,
   parameter int                ZOOM_MIN = 0,
   parameter int                ZOOM_MAX = 4,
   parameter int                ZOOM_DIV = 128
) (
   input  logic              px_clk,
   input  logic              rst,
   input  logic              endframe,
   input  logic              run,
   input  logic              dir,
   input  logic              load,
   input  logic [DATA_W-1:0] load_val,
   output logic [DATA_W-1:0] register,
   output logic [ZOOM_W-1:0] zoom,
   output logic              zoom_up,
   output logic              tick,
   output logic              led
);

   localparam int RC_W = (REG_DIV > 1) ? $clog2(REG_DIV) : 1;
   localparam int ZC_W = (ZOOM_DIV > 1) ? $clog2(ZOOM_DIV) : 1;

   localparam logic [RC_W-1:0]   REG_LAST = RC_W'(REG_DIV - 1);
   localparam logic [ZC_W-1:0]   ZM_LAST  = ZC_W'(ZOOM_DIV - 1);
   localparam logic [DATA_W-1:0] STEP_V   = DATA_W'(STEP);
   localparam logic [ZOOM_W-1:0] ZMIN     = ZOOM_W'(ZOOM_MIN);
   localparam logic [ZOOM_W-1:0] ZMAX     = ZOOM_W'(ZOOM_MAX);
   localparam logic [ZOOM_W-1:0] ZMIN_UP  = ZOOM_W'(ZOOM_MIN + 1);
   localparam logic [ZOOM_W-1:0] ZMAX_DN  = ZOOM_W'((ZOOM_MAX > 0) ? ZOOM_MAX - 1 : 0);
   localparam bit                PINGPONG = (ZOOM_MAX != ZOOM_MIN);

   logic              r_endframe_q;
   logic [RC_W-1:0]   r_reg_cnt;
   logic [ZC_W-1:0]   r_zm_cnt;
   logic              w_fe;
   logic              w_adv;

   assign w_fe  = endframe & ~r_endframe_q;
   assign w_adv = w_fe & run;

   // Edge detector and register path. The delayed endframe is forced high in
   // reset so a level already present at reset release is not seen as an edge.
   // NOTE: all state here uses non-blocking assignments so every branch reads
   // the pre-edge values regardless of statement order.
   always_ff @(posedge px_clk) begin
      r_endframe_q <= endframe;
      if (rst) begin
         r_endframe_q <= 1'b1;
         register     <= INIT;
         r_reg_cnt    <= '0;
         tick         <= 1'b0;
      end else if (load) begin
         register  <= load_val;
         r_reg_cnt <= '0;
         tick      <= 1'b0;
      end else if (w_adv) begin
         if (r_reg_cnt == REG_LAST) begin
            r_reg_cnt <= '0;
            register  <= dir ? (register - STEP_V) : (register + STEP_V);
            tick      <= 1'b1;
         end else begin
            r_reg_cnt <= r_reg_cnt + 1'b1;
            tick      <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

   // Zoom ping-pong: endpoints are visited once per sweep, and a degenerate
   // range keeps the level fixed while the heartbeat still toggles.
   always_ff @(posedge px_clk) begin
      if (rst) begin
         zoom     <= ZMIN;
         zoom_up  <= 1'b1;
         led      <= 1'b0;
         r_zm_cnt <= '0;
      end else if (w_adv) begin
         if (r_zm_cnt == ZM_LAST) begin
            r_zm_cnt <= '0;
            led      <= ~led;
            if (PINGPONG) begin
               if (zoom_up) begin
                  if (zoom == ZMAX) begin
                     zoom_up <= 1'b0;
                     zoom    <= ZMAX_DN;
                  end else begin
                     zoom <= zoom + 1'b1;
                  end
               end else begin
                  if (zoom == ZMIN) begin
                     zoom_up <= 1'b1;
                     zoom    <= ZMIN_UP;
                  end else begin
                     zoom <= zoom - 1'b1;
                  end
               end
            end
         end else begin
            r_zm_cnt <= r_zm_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frame_anim_ctl.sv
// Self-checking bench for frame_anim_ctl: three parameterisations share one
// stimulus stream and are compared every cycle against an abstract model.
module tb_frame_anim_ctl;

   localparam int NI = 3;

   logic        px_clk = 1'b0;
   logic        rst = 1'b1;
   logic        endframe = 1'b0;
   logic        run = 1'b1;
   logic        dir = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_val = '0;

   logic [15:0] o_reg  [NI];
   logic [2:0]  o_zoom [NI];
   logic        o_up   [NI];
   logic        o_tick [NI];
   logic        o_led  [NI];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 px_clk = ~px_clk;

   frame_anim_ctl u_a (
      .px_clk(px_clk), .rst(rst), .endframe(endframe), .run(run), .dir(dir),
      .load(load), .load_val(load_val), .register(o_reg[0]), .zoom(o_zoom[0]),
      .zoom_up(o_up[0]), .tick(o_tick[0]), .led(o_led[0]));

   frame_anim_ctl #(.STEP(3), .REG_DIV(1), .ZOOM_DIV(2)) u_b (
      .px_clk(px_clk), .rst(rst), .endframe(endframe), .run(run), .dir(dir),
      .load(load), .load_val(load_val), .register(o_reg[1]), .zoom(o_zoom[1]),
      .zoom_up(o_up[1]), .tick(o_tick[1]), .led(o_led[1]));

   frame_anim_ctl #(.INIT(16'hFFFE), .REG_DIV(3), .ZOOM_MIN(2), .ZOOM_MAX(2), .ZOOM_DIV(1)) u_c (
      .px_clk(px_clk), .rst(rst), .endframe(endframe), .run(run), .dir(dir),
      .load(load), .load_val(load_val), .register(o_reg[2]), .zoom(o_zoom[2]),
      .zoom_up(o_up[2]), .tick(o_tick[2]), .led(o_led[2]));

   // Parameters of each instance, as seen by the model.
   function automatic logic [15:0] p_init(int i);
      return (i == 2) ? 16'hFFFE : 16'h0019;
   endfunction
   function automatic int p_step(int i);     return (i == 1) ? 3 : 1; endfunction
   function automatic int p_reg_div(int i);  return (i == 0) ? 16 : ((i == 1) ? 1 : 3); endfunction
   function automatic int p_zoom_div(int i); return (i == 0) ? 128 : ((i == 1) ? 2 : 1); endfunction
   function automatic int p_zmin(int i);     return (i == 2) ? 2 : 0; endfunction
   function automatic int p_zmax(int i);     return (i == 2) ? 2 : 4; endfunction

   // Zoom level and direction as a closed form of the number of zoom steps taken.
   function automatic int zoom_of(int i, int k);
      int range = p_zmax(i) - p_zmin(i);
      int p;
      if (range == 0) return p_zmin(i);
      p = k % (2 * range);
      return (p <= range) ? p_zmin(i) + p : p_zmin(i) + 2 * range - p;
   endfunction
   function automatic bit up_of(int i, int k);
      int range = p_zmax(i) - p_zmin(i);
      int p;
      if (range == 0 || k == 0) return 1'b1;
      p = k % (2 * range);
      return (p >= 1) && (p <= range);
   endfunction

   // Model state
   logic        m_efq = 1'b1;
   logic [15:0] m_reg  [NI];
   int          m_rcnt [NI];
   logic        m_tick [NI];
   int          m_zk   [NI];
   int          m_zcnt [NI];

   int   tick_cnt [NI];
   int   led_chg  [NI];
   logic led_prev [NI];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: advance the model from the pre-edge inputs, then compare all outputs.
   task automatic cyc();
      bit fe = endframe && !m_efq;
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            m_reg[i] = p_init(i); m_rcnt[i] = 0; m_tick[i] = 1'b0;
            m_zk[i] = 0; m_zcnt[i] = 0;
         end else begin
            if (load) begin
               m_reg[i] = load_val; m_rcnt[i] = 0; m_tick[i] = 1'b0;
            end else if (fe && run) begin
               m_rcnt[i]++;
               if (m_rcnt[i] == p_reg_div(i)) begin
                  m_rcnt[i] = 0;
                  m_reg[i] = dir ? m_reg[i] - 16'(p_step(i)) : m_reg[i] + 16'(p_step(i));
                  m_tick[i] = 1'b1;
               end else begin
                  m_tick[i] = 1'b0;
               end
            end else begin
               m_tick[i] = 1'b0;
            end
            if (fe && run) begin
               m_zcnt[i]++;
               if (m_zcnt[i] == p_zoom_div(i)) begin
                  m_zcnt[i] = 0;
                  m_zk[i]++;
               end
            end
         end
      end
      m_efq = rst ? 1'b1 : endframe;
      @(posedge px_clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("model_reg%0d", i),  32'(o_reg[i]),  32'(m_reg[i]));
         check($sformatf("model_tick%0d", i), 32'(o_tick[i]), 32'(m_tick[i]));
         check($sformatf("model_zoom%0d", i), 32'(o_zoom[i]), 32'(zoom_of(i, m_zk[i])));
         check($sformatf("model_up%0d", i),   32'(o_up[i]),   32'(up_of(i, m_zk[i])));
         check($sformatf("model_led%0d", i),  32'(o_led[i]),  32'(m_zk[i] % 2));
         if (o_tick[i] === 1'b1) tick_cnt[i]++;
         if (o_led[i] !== led_prev[i]) led_chg[i]++;
         led_prev[i] = o_led[i];
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < NI; i++) begin
         tick_cnt[i] = 0;
         led_chg[i] = 0;
      end
   endtask

   // Reset, then one idle cycle with endframe low so the next rise is an event.
   task automatic do_reset();
      rst = 1'b1; endframe = 1'b0; load = 1'b0; run = 1'b1; dir = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      clear_counts();
   endtask

   task automatic frames(input int n);
      for (int f = 0; f < n; f++) begin
         endframe = 1'b1; cyc();
         endframe = 1'b0; cyc();
      end
   endtask

   typedef struct {
      bit          rst, ef, run, load;
      logic [15:0] lval;
      logic [15:0] exp_reg;
      bit          exp_tick;
   } vec_t;

   vec_t tbl[10];
   int   exp_zoom[10];
   bit   exp_up[10];

   initial begin
      for (int i = 0; i < NI; i++) led_prev[i] = 1'b0;
      clear_counts();

      tbl[0] = '{1, 1, 1, 0, 16'h0000, 16'h0019, 0};
      tbl[1] = '{1, 1, 1, 0, 16'h0000, 16'h0019, 0};
      tbl[2] = '{1, 1, 1, 0, 16'h0000, 16'h0019, 0};
      tbl[3] = '{0, 1, 1, 0, 16'h0000, 16'h0019, 0};
      tbl[4] = '{0, 1, 1, 0, 16'h0000, 16'h0019, 0};
      tbl[5] = '{0, 0, 1, 0, 16'h0000, 16'h0019, 0};
      tbl[6] = '{0, 1, 1, 1, 16'h1234, 16'h1234, 0};
      tbl[7] = '{0, 0, 1, 0, 16'h0000, 16'h1234, 0};
      tbl[8] = '{0, 0, 0, 1, 16'h00AA, 16'h00AA, 0};
      tbl[9] = '{0, 1, 0, 0, 16'h0000, 16'h00AA, 0};

      // Reset with endframe held high, edge suppression, load priority and load while paused.
      for (int v = 0; v < 10; v++) begin
         rst = tbl[v].rst; endframe = tbl[v].ef; run = tbl[v].run;
         load = tbl[v].load; load_val = tbl[v].lval; dir = 1'b0;
         cyc();
         check($sformatf("tbl_reg%0d", v),  32'(o_reg[0]),  32'(tbl[v].exp_reg));
         check($sformatf("tbl_tick%0d", v), 32'(o_tick[0]), 32'(tbl[v].exp_tick));
         if (v == 2) begin
            check("rst_zoom", 32'(o_zoom[0]), 32'd0);
            check("rst_up",   32'(o_up[0]),   32'd1);
            check("rst_led",  32'(o_led[0]),  32'd0);
         end
      end
      load = 1'b0;

      // Register stepping: 48 frames.
      do_reset();
      frames(48);
      check("step_reg_a",   32'(o_reg[0]), 32'h001C);
      check("step_ticks_a", 32'(tick_cnt[0]), 32'd3);
      check("step_reg_b",   32'(o_reg[1]), 32'h00A9);
      check("step_ticks_b", 32'(tick_cnt[1]), 32'd48);
      check("step_reg_c",   32'(o_reg[2]), 32'h000E);

      // Zoom ping-pong on the ZOOM_DIV=2 instance.
      exp_zoom = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
      exp_up   = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
      do_reset();
      for (int k = 0; k < 10; k++) begin
         frames(2);
         check($sformatf("pp_zoom%0d", k), 32'(o_zoom[1]), 32'(exp_zoom[k]));
         check($sformatf("pp_up%0d", k),   32'(o_up[1]),   32'(exp_up[k]));
      end
      check("pp_led_b",  32'(led_chg[1]), 32'd10);
      check("pp_led_c",  32'(led_chg[2]), 32'd20);
      check("pp_zoom_c", 32'(o_zoom[2]), 32'd2);
      check("pp_up_c",   32'(o_up[2]), 32'd1);

      // Pause mid-count.
      do_reset();
      frames(8);
      run = 1'b0; frames(20);
      run = 1'b1; frames(8);
      check("pause_reg",   32'(o_reg[0]), 32'h001A);
      check("pause_ticks", 32'(tick_cnt[0]), 32'd1);

      // Load in the same cycle as the 16th frame event.
      do_reset();
      frames(15);
      load = 1'b1; load_val = 16'h5555; endframe = 1'b1; cyc();
      load = 1'b0; endframe = 1'b0; cyc();
      check("ldpri_reg",   32'(o_reg[0]), 32'h5555);
      check("ldpri_ticks", 32'(tick_cnt[0]), 32'd0);
      frames(15);
      check("ldpri_hold", 32'(o_reg[0]), 32'h5555);
      frames(1);
      check("ldpri_step", 32'(o_reg[0]), 32'h5556);

      // Wrap in both directions.
      load = 1'b1; load_val = 16'hFFFF; cyc();
      load = 1'b0;
      dir = 1'b0; frames(16);
      check("wrap_up", 32'(o_reg[0]), 32'h0000);
      dir = 1'b1; frames(16);
      check("wrap_dn", 32'(o_reg[0]), 32'hFFFF);

      // Reset in the middle of a count.
      do_reset();
      frames(10);
      do_reset();
      check("mid_rst_reg", 32'(o_reg[0]), 32'h0019);
      frames(15);
      check("mid_rst_hold", 32'(o_reg[0]), 32'h0019);
      frames(1);
      check("mid_rst_step", 32'(o_reg[0]), 32'h001A);

      // Randomised traffic against the model.
      for (int c = 0; c < 6000; c++) begin
         rst      = ($urandom_range(299) == 0);
         endframe = ($urandom_range(2) == 0);
         run      = ($urandom_range(7) != 0);
         if ($urandom_range(40) == 0) dir = ~dir;
         load     = ($urandom_range(99) == 0);
         case ($urandom_range(3))
            0:       load_val = 16'hFFFF;
            1:       load_val = 16'h0000;
            default: load_val = 16'($urandom);
         endcase
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
